// File: rtl/keccak_pkg.sv
// Shared definitions for the Keccak lane buffer: lane geometry, rate lookup
// and the per-bank state encoding.
package keccak_pkg;

  localparam int LANE_W    = 64;
  localparam int MAX_LANES = 20;
  localparam int BLK_W     = LANE_W * MAX_LANES;
  localparam int CNT_W     = 5;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_e;

  // Rate select to lane count; modes 1 and 3 both give 16 lanes.
  function automatic logic [CNT_W-1:0] rate_of(input logic [1:0] mode);
    logic [CNT_W-1:0] lanes;
    case (mode)
      2'd0:    lanes = 5'd8;
      2'd1:    lanes = 5'd16;
      2'd2:    lanes = 5'd20;
      default: lanes = 5'd16;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/keccak_lane_buffer_if.sv
// Lane-in / block-out bundle between padder, lane buffer and absorb stage.
// The slave modport is the buffer's view, master is the driving side.
interface keccak_lane_buffer_if;
  import keccak_pkg::*;

  logic [1:0]        mode;
  logic [LANE_W-1:0] in;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [BLK_W-1:0]  blk_data;
  logic [CNT_W-1:0]  blk_lanes;
  logic              blk_last;
  logic              blk_valid;
  logic              blk_ready;
  logic              overflow;

  modport master (
    output mode, in, in_valid, in_last, blk_ready,
    input  in_ready, blk_data, blk_lanes, blk_last, blk_valid, overflow
  );

  modport slave (
    input  mode, in, in_valid, in_last, blk_ready,
    output in_ready, blk_data, blk_lanes, blk_last, blk_valid, overflow
  );

endinterface

// File: rtl/keccak_lane_bank.sv
// One storage bank of the lane buffer: indexed lane writes, whole-bank clear,
// plus the bank's fill state, latched rate and final-block flag.
module keccak_lane_bank
  import keccak_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [CNT_W-1:0]  wr_idx,
  input  logic [LANE_W-1:0] wr_data,
  input  logic              wr_last,
  input  logic              wr_final,
  input  logic [CNT_W-1:0]  wr_rate,
  input  logic              clr,
  output bank_state_e       state,
  output logic [CNT_W-1:0]  rate,
  output logic              last,
  output logic [BLK_W-1:0]  data
);

  bank_state_e      state_reg;
  logic [CNT_W-1:0] rate_reg;
  logic             last_reg;

  // Lane registers; all lanes are cleared together when the block is consumed
  // so unused lanes of a shorter rate always read back as zero.
  for (genvar gi = 0; gi < MAX_LANES; gi++) begin : g_lane
    logic [LANE_W-1:0] lane_reg;

    // Per-lane write or clear.
    always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
        lane_reg <= '0;
      end else if (wr_en && (wr_idx == CNT_W'(gi))) begin
        lane_reg <= wr_data;
      end
    end

    assign data[gi*LANE_W +: LANE_W] = lane_reg;
  end

  // Bank fill FSM; rate is captured only on the first lane of a block.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      state_reg <= EMPTY;
      rate_reg  <= '0;
      last_reg  <= 1'b0;
    end else if (wr_en) begin
      if (state_reg == EMPTY) begin
        rate_reg <= wr_rate;
      end
      last_reg  <= last_reg | wr_last;
      state_reg <= wr_final ? FULL : FILLING;
    end
  end

  assign state = state_reg;
  assign rate  = rate_reg;
  assign last  = last_reg;

endmodule

// File: rtl/keccak_lane_buffer.sv
// Double-buffered lane collector: gathers padded lanes into rate-sized blocks
// in two ping-pong banks and presents full blocks over valid/ready.
// Build option: define KECCAK_LANE_BSWAP_EN to byte-reverse every lane on write.
module keccak_lane_buffer
  import keccak_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  keccak_lane_buffer_if.slave  bus
);

  logic             wr_sel_reg;
  logic             rd_sel_reg;
  logic [CNT_W-1:0] lane_cnt_reg;
  logic             overflow_reg;

  bank_state_e      wr_state;
  bank_state_e      rd_state;
  logic [CNT_W-1:0] wr_rate_latched;
  logic [CNT_W-1:0] eff_rate;
  logic             accept;
  logic             wr_final;
  logic             consume;
  logic [LANE_W-1:0] lane_data;

  // Lane byte order as stored in the bank.
  function automatic logic [LANE_W-1:0] lane_order(input logic [LANE_W-1:0] d);
    logic [LANE_W-1:0] r;
`ifdef KECCAK_LANE_BSWAP_EN
    for (int b = 0; b < LANE_W/8; b++) begin
      r[LANE_W-8-8*b +: 8] = d[8*b +: 8];
    end
`else
    r = d;
`endif
    return r;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    bank_state_e      state;
    logic [CNT_W-1:0] rate;
    logic             last;
    logic [BLK_W-1:0] data;

    keccak_lane_bank u_bank (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (accept && (wr_sel_reg == 1'(gi))),
      .wr_idx   (lane_cnt_reg),
      .wr_data  (lane_data),
      .wr_last  (bus.in_last),
      .wr_final (wr_final),
      .wr_rate  (rate_of(bus.mode)),
      .clr      (consume && (rd_sel_reg == 1'(gi))),
      .state    (state),
      .rate     (rate),
      .last     (last),
      .data     (data)
    );
  end

  assign wr_state        = wr_sel_reg ? g_bank[1].state : g_bank[0].state;
  assign rd_state        = rd_sel_reg ? g_bank[1].state : g_bank[0].state;
  assign wr_rate_latched = wr_sel_reg ? g_bank[1].rate  : g_bank[0].rate;

  // An empty write bank has not latched its rate yet, so use the live mode.
  assign eff_rate  = (wr_state == EMPTY) ? rate_of(bus.mode) : wr_rate_latched;
  assign wr_final  = (lane_cnt_reg == (eff_rate - 5'd1));
  assign accept    = bus.in_valid && bus.in_ready;
  assign consume   = bus.blk_valid && bus.blk_ready;
  assign lane_data = lane_order(bus.in);

  assign bus.in_ready  = (wr_state != FULL);
  assign bus.blk_valid = (rd_state == FULL);
  assign bus.blk_data  = rd_sel_reg ? g_bank[1].data : g_bank[0].data;
  assign bus.blk_lanes = rd_sel_reg ? g_bank[1].rate : g_bank[0].rate;
  assign bus.blk_last  = rd_sel_reg ? g_bank[1].last : g_bank[0].last;
  assign bus.overflow  = overflow_reg;

  // Bank pointers, lane index and sticky overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_sel_reg   <= 1'b0;
      rd_sel_reg   <= 1'b0;
      lane_cnt_reg <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (accept) begin
        if (wr_final) begin
          lane_cnt_reg <= '0;
          wr_sel_reg   <= ~wr_sel_reg;
        end else begin
          lane_cnt_reg <= lane_cnt_reg + 5'd1;
        end
      end
      if (consume) begin
        rd_sel_reg <= ~rd_sel_reg;
      end
      if (bus.in_valid && !bus.in_ready) begin
        overflow_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_keccak_lane_buffer.sv
// Self-checking bench for keccak_lane_buffer: a vector table, directed
// corner-case sequences and randomized traffic against a queue-based model.
module tb_keccak_lane_buffer;
  import keccak_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  keccak_lane_buffer_if bus();

  keccak_lane_buffer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: completed blocks queue plus the block being gathered.
  typedef struct packed {
    logic [BLK_W-1:0] data;
    logic [4:0]       rate;
    logic             last;
  } blk_t;

  blk_t             fq[$];
  logic [BLK_W-1:0] p_data = '0;
  int               p_cnt = 0;
  int               p_rate = 0;
  bit               p_last = 0;
  bit               m_ovf = 0;

  typedef struct {
    bit          v;
    bit          l;
    logic [1:0]  m;
    logic [63:0] d;
    bit          br;
    bit          e_rdy;
    bit          e_val;
    logic [4:0]  e_lanes;
  } vec_t;

  vec_t tv[10];

  function automatic int tb_rate(input logic [1:0] m);
    if (m == 2'd0) return 8;
    if (m == 2'd2) return 20;
    return 16;
  endfunction

  function automatic logic [63:0] tb_swap(input logic [63:0] d);
`ifdef KECCAK_LANE_BSWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24], d[39:32], d[47:40], d[55:48], d[63:56]};
`else
    return d;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_data(input string name, input logic [BLK_W-1:0] exp);
    checks++;
    if (bus.blk_data !== exp) begin
      failures++;
      for (int i = 0; i < MAX_LANES; i++) begin
        if (bus.blk_data[i*LANE_W +: LANE_W] !== exp[i*LANE_W +: LANE_W]) begin
          $display("FAIL %s lane=%0d actual=%0h required=%0h", name, i,
                   bus.blk_data[i*LANE_W +: LANE_W], exp[i*LANE_W +: LANE_W]);
          break;
        end
      end
    end
  endtask

  task automatic check_model();
    chk("in_ready", 64'(bus.in_ready), 64'(fq.size() < 2));
    chk("blk_valid", 64'(bus.blk_valid), 64'(fq.size() > 0));
    chk("overflow", 64'(bus.overflow), 64'(m_ovf));
    if (fq.size() > 0) begin
      chk_data("blk_data", fq[0].data);
      chk("blk_lanes", 64'(bus.blk_lanes), 64'(fq[0].rate));
      chk("blk_last", 64'(bus.blk_last), 64'(fq[0].last));
    end else begin
      chk_data("blk_data_idle", p_data);
      chk("blk_last_idle", 64'(bus.blk_last), 64'(p_last));
    end
  endtask

  task automatic drive(input bit v, input bit l, input logic [1:0] m,
                       input logic [63:0] d, input bit br);
    bus.in_valid  = v;
    bus.in_last   = l;
    bus.mode      = m;
    bus.in        = d;
    bus.blk_ready = br;
  endtask

  // One clock: advance the model with the pre-edge inputs, then compare.
  task automatic cycle();
    bit   rdy;
    bit   acc;
    bit   cons;
    blk_t b;
    rdy  = (fq.size() < 2);
    acc  = bus.in_valid && rdy;
    cons = (fq.size() > 0) && bus.blk_ready;
    @(posedge clk);
    if (!rst_n) begin
      fq.delete();
      p_data = '0;
      p_cnt  = 0;
      p_rate = 0;
      p_last = 0;
      m_ovf  = 0;
    end else begin
      if (cons) begin
        $display("block out lanes=%0d last=%0d lane0=%h", fq[0].rate, fq[0].last, fq[0].data[63:0]);
        void'(fq.pop_front());
      end
      if (bus.in_valid && !rdy) m_ovf = 1;
      if (acc) begin
        if (p_cnt == 0) p_rate = tb_rate(bus.mode);
        p_data[p_cnt*LANE_W +: LANE_W] = tb_swap(bus.in);
        p_last = p_last | bus.in_last;
        p_cnt++;
        if (p_cnt == p_rate) begin
          b.data = p_data;
          b.rate = 5'(p_rate);
          b.last = p_last;
          fq.push_back(b);
          p_data = '0;
          p_cnt  = 0;
          p_last = 0;
        end
      end
    end
    #1;
    check_model();
  endtask

  initial begin
    drive(0, 0, 2'd0, 64'h0, 0);
    rst_n = 1'b0;
    cycle();
    cycle();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_blk_valid", 64'(bus.blk_valid), 64'd0);
    chk("rst_blk_lanes", 64'(bus.blk_lanes), 64'd0);
    chk("rst_blk_last", 64'(bus.blk_last), 64'd0);
    chk("rst_overflow", 64'(bus.overflow), 64'd0);
    chk("rst_data_zero", 64'(|bus.blk_data), 64'd0);
    rst_n = 1'b1;

    // Mode 0, lanes 1..8 back-to-back, then hold one cycle, then accept.
    for (int i = 0; i < 8; i++) begin
      tv[i].v = 1; tv[i].l = 0; tv[i].m = 2'd0; tv[i].d = 64'(i + 1); tv[i].br = 1;
      tv[i].e_rdy = 1; tv[i].e_val = (i == 7); tv[i].e_lanes = (i == 7) ? 5'd8 : 5'd0;
    end
    tv[8].v = 0; tv[8].l = 0; tv[8].m = 2'd0; tv[8].d = 64'h0; tv[8].br = 0;
    tv[8].e_rdy = 1; tv[8].e_val = 1; tv[8].e_lanes = 5'd8;
    tv[9].v = 0; tv[9].l = 0; tv[9].m = 2'd0; tv[9].d = 64'h0; tv[9].br = 1;
    tv[9].e_rdy = 1; tv[9].e_val = 0; tv[9].e_lanes = 5'd0;
    for (int i = 0; i < 10; i++) begin
      drive(tv[i].v, tv[i].l, tv[i].m, tv[i].d, tv[i].br);
      cycle();
      chk($sformatf("tbl%0d_in_ready", i), 64'(bus.in_ready), 64'(tv[i].e_rdy));
      chk($sformatf("tbl%0d_blk_valid", i), 64'(bus.blk_valid), 64'(tv[i].e_val));
      if (tv[i].e_val) chk($sformatf("tbl%0d_lanes", i), 64'(bus.blk_lanes), 64'(tv[i].e_lanes));
      if (i == 8) begin
        chk("tbl_lane0", bus.blk_data[63:0], tb_swap(64'h1));
        chk("tbl_lane7", bus.blk_data[7*64 +: 64], tb_swap(64'h8));
        chk("tbl_hi_zero", 64'(|bus.blk_data[BLK_W-1:8*64]), 64'd0);
      end
    end

    // Mode switched 0->1 after lane 3: block stays 8 lanes, next one 16.
    for (int k = 0; k < 24; k++) begin
      drive(1, 0, (k < 3) ? 2'd0 : 2'd1, 64'(16'h100 + k), 1);
      cycle();
      if (k == 7) chk("msw_first_lanes", 64'(bus.blk_lanes), 64'd8);
      if (k == 23) chk("msw_second_lanes", 64'(bus.blk_lanes), 64'd16);
    end
    drive(0, 0, 2'd1, 64'h0, 1);
    cycle();

    // in_last on lane 16 of a mode-1 block marks only that block.
    for (int k = 0; k < 32; k++) begin
      drive(1, (k == 15), 2'd1, 64'(16'h200 + k), 1);
      cycle();
      if (k == 15) chk("last_set", 64'(bus.blk_last), 64'd1);
      if (k == 31) chk("last_next_clear", 64'(bus.blk_last), 64'd0);
    end
    drive(0, 0, 2'd1, 64'h0, 1);
    cycle();

    // Mode 2 with consumer stalled: both banks fill, 41st lane overflows.
    for (int k = 0; k < 41; k++) begin
      drive(1, 0, 2'd2, 64'(16'h300 + k), 0);
      cycle();
      if (k == 39) chk("ovf_ready_low", 64'(bus.in_ready), 64'd0);
      if (k == 40) chk("ovf_sticky", 64'(bus.overflow), 64'd1);
    end
    drive(0, 0, 2'd2, 64'h0, 1);
    cycle();
    chk("ovf_ready_back", 64'(bus.in_ready), 64'd1);
    cycle();

    // Reset in the middle of a mode-3 block, then a clean block.
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 2'd3, 64'(16'h400 + k), 0);
      cycle();
    end
    drive(0, 0, 2'd3, 64'h0, 0);
    rst_n = 1'b0;
    cycle();
    chk("mrst_blk_valid", 64'(bus.blk_valid), 64'd0);
    chk("mrst_overflow", 64'(bus.overflow), 64'd0);
    chk("mrst_lanes", 64'(bus.blk_lanes), 64'd0);
    chk("mrst_data_zero", 64'(|bus.blk_data), 64'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      drive(1, 0, 2'd3, 64'(16'hA00 + k), 0);
      cycle();
    end
    chk("mrst_clean_lane0", bus.blk_data[63:0], tb_swap(64'hA00));
    chk("mrst_clean_lanes", 64'(bus.blk_lanes), 64'd16);
    drive(0, 0, 2'd3, 64'h0, 1);
    cycle();

    // Lane byte order on store.
    for (int k = 0; k < 8; k++) begin
      drive(1, 0, 2'd0, (k == 0) ? 64'h0102030405060708 : 64'(k), 0);
      cycle();
    end
`ifdef KECCAK_LANE_BSWAP_EN
    chk("bswap_lane0", bus.blk_data[63:0], 64'h0807060504030201);
`else
    chk("bswap_lane0", bus.blk_data[63:0], 64'h0102030405060708);
`endif
    drive(0, 0, 2'd0, 64'h0, 1);
    cycle();

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
            2'($urandom_range(0, 3)), {$urandom, $urandom}, $urandom_range(0, 2) != 0);
      rst_n = ($urandom_range(0, 199) != 0);
      cycle();
    end
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
